hsid_ref_fetch_ctrl: RTL and testbench

Scheduler that streams library reference spectra from system memory into the reference FIFO that feeds the main MSE datapath. It issues OBI-style read requests over a sequential band-pack address walk and limits traffic with FIFO credits, so the reference FIFO never overflows. It sits between the bus master port and the reference FIFO, and is started and cleared alongside the main FSM.

---
 rtl/hsid_ref_fetch_ctrl_if.sv | 30 +++
 rtl/hsid_ref_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_hsid_ref_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsid_ref_fetch_ctrl_if.sv
// Bus-side bundle of the reference fetcher: OBI-style read port plus the
// write/credit port of the reference FIFO. master = fetcher, slave = environment.
interface hsid_ref_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  fifo_ref_push;
  logic [WORD_WIDTH-1:0] fifo_ref_data;
  logic                  fifo_ref_last;
  logic                  fifo_ref_pop;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output fifo_ref_push, fifo_ref_data, fifo_ref_last,
    input  fifo_ref_pop
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  fifo_ref_push, fifo_ref_data, fifo_ref_last,
    output fifo_ref_pop
  );
endinterface

// File: rtl/hsid_ref_fetch_ctrl.sv
// Reference spectrum fetcher: credit-limited OBI read walk over the library into the reference FIFO.
// Optional HSID_REF_FETCH_STRIDE_EN adds lib_stride_i for a per-reference byte stride.
module hsid_ref_fetch_ctrl #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 8,
  parameter int MAX_OUTSTANDING   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_i,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size_i,
  input  logic [ADDR_WIDTH-1:0]        lib_base_addr_i,
`ifdef HSID_REF_FETCH_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]        lib_stride_i,
`endif
  hsid_ref_fetch_ctrl_if.master        bus_if,
  output logic                         idle_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         cancelled_o
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CRED_W-1:0]            CRED_FULL  = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0]            CRED_ZERO  = {CRED_W{1'b0}};
  localparam logic [CRED_W-1:0]            CRED_ONE   = {{(CRED_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]             OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]             OUT_ZERO   = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]             OUT_ONE    = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [HSP_BANDS_WIDTH-1:0]   W_ZERO     = {HSP_BANDS_WIDTH{1'b0}};
  localparam logic [HSP_BANDS_WIDTH-1:0]   W_ONE      = {{(HSP_BANDS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HSP_LIBRARY_WIDTH-1:0] L_ZERO     = {HSP_LIBRARY_WIDTH{1'b0}};
  localparam logic [HSP_LIBRARY_WIDTH-1:0] L_ONE      = {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]        WORD_BYTES = ADDR_WIDTH'(3'd4);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;
  localparam logic [2:0] S_CLEAR  = 3'd6;

  logic [2:0]                   state_q, state_d;
  logic                         clr_pend_q, clr_pend_d;
  logic [HSP_BANDS_WIDTH-1:0]   cfg_words_q, cfg_words_d;
  logic [HSP_LIBRARY_WIDTH-1:0] cfg_lib_q, cfg_lib_d;
  logic [HSP_BANDS_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_idx_q, ref_idx_d;
  logic [HSP_BANDS_WIDTH-1:0]   rsp_word_q, rsp_word_d;
  logic [HSP_LIBRARY_WIDTH-1:0] rsp_ref_q, rsp_ref_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [CRED_W-1:0]            credits_q, credits_d;
  logic [OUT_W-1:0]             outst_q, outst_d;
`ifdef HSID_REF_FETCH_STRIDE_EN
  logic [ADDR_WIDTH-1:0]        stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]        ref_base_q, ref_base_d;
  logic [ADDR_WIDTH-1:0]        stride_min_s;
`endif

  logic [HSP_BANDS_WIDTH-1:0] words_in_s;
  logic cfg_err_s, mem_req_s, gnt_s, rv_s, rsp_err_s, push_s;
  logic word_last_s, rsp_last_s, last_issue_s, rsp_done_s;

  // Configuration decode: two bands per word, rounded up.
  always_comb begin
    words_in_s = (hsp_bands_i >> 1) + {{(HSP_BANDS_WIDTH-1){1'b0}}, hsp_bands_i[0]};
    cfg_err_s  = (hsp_bands_i == W_ZERO) || (hsp_library_size_i == L_ZERO) ||
                 (lib_base_addr_i[1:0] != 2'b00);
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride_min_s = ADDR_WIDTH'({words_in_s, 2'b00});
    cfg_err_s    = cfg_err_s || (lib_stride_i[1:0] != 2'b00) || (lib_stride_i < stride_min_s);
`endif
  end

  // mem_req depends only on registers; credits/outstanding only relax without gnt, so it holds until accepted.
  assign word_last_s  = (word_idx_q == (cfg_words_q - W_ONE));
  assign rsp_last_s   = (rsp_word_q == (cfg_words_q - W_ONE));
  assign last_issue_s = word_last_s && (ref_idx_q == (cfg_lib_q - L_ONE));
  assign rsp_done_s   = (rsp_ref_q == cfg_lib_q);
  assign mem_req_s    = (state_q == S_FETCH) && !clr_pend_q && (credits_q != CRED_ZERO) &&
                        (outst_q < OUT_MAX) && (ref_idx_q != cfg_lib_q);
  assign gnt_s        = mem_req_s && bus_if.mem_gnt;
  assign rv_s         = bus_if.mem_rvalid && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign rsp_err_s    = rv_s && (outst_q == OUT_ZERO);
  assign push_s       = rv_s && !rsp_err_s && !clr_pend_q && !clear_i;

  assign bus_if.mem_req       = mem_req_s;
  assign bus_if.mem_addr      = addr_q;
  assign bus_if.fifo_ref_push = push_s;
  assign bus_if.fifo_ref_data = bus_if.mem_rdata;
  assign bus_if.fifo_ref_last = push_s && rsp_last_s;

  assign idle_o      = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERROR);
  assign cancelled_o = (state_q == S_CLEAR);

  // Credit and outstanding-read bookkeeping.
  always_comb begin
    outst_d = outst_q;
    case ({gnt_s, rv_s && !rsp_err_s})
      2'b10:   outst_d = outst_q + OUT_ONE;
      2'b01:   outst_d = outst_q - OUT_ONE;
      default: outst_d = outst_q;
    endcase
    credits_d = credits_q;
    case ({gnt_s, bus_if.fifo_ref_pop})
      2'b10:   credits_d = credits_q - CRED_ONE;
      2'b01:   credits_d = (credits_q < CRED_FULL) ? (credits_q + CRED_ONE) : credits_q;
      default: credits_d = credits_q;
    endcase
    if ((state_q == S_CLEAR) || (state_q == S_ERROR)) begin
      credits_d = CRED_FULL;
      outst_d   = OUT_ZERO;
    end else if (state_q == S_DONE) begin
      outst_d   = OUT_ZERO;
    end else begin
      outst_d   = outst_d;
    end
  end

  // Control FSM; a pending clear waits for in-flight reads before reporting cancelled.
  always_comb begin
    state_d    = state_q;
    clr_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_CONFIG;
        else         state_d = S_IDLE;
      end
      S_CONFIG: begin
        if (clear_i)        state_d = S_CLEAR;
        else if (cfg_err_s) state_d = S_ERROR;
        else                state_d = S_FETCH;
      end
      S_FETCH, S_DRAIN: begin
        if (rsp_err_s) begin
          state_d = S_ERROR;
        end else if (clear_i || clr_pend_q) begin
          if (outst_d == OUT_ZERO) begin
            state_d = S_CLEAR;
          end else begin
            state_d    = state_q;
            clr_pend_d = 1'b1;
          end
        end else if (state_q == S_FETCH) begin
          if (gnt_s && last_issue_s) state_d = S_DRAIN;
          else                       state_d = S_FETCH;
        end else begin
          if ((outst_q == OUT_ZERO) && rsp_done_s) state_d = S_DONE;
          else                                     state_d = S_DRAIN;
        end
      end
      S_DONE, S_ERROR, S_CLEAR: state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Issue walk and response tracking; addresses advance incrementally instead of multiplying.
  always_comb begin
    cfg_words_d = cfg_words_q;
    cfg_lib_d   = cfg_lib_q;
    word_idx_d  = word_idx_q;
    ref_idx_d   = ref_idx_q;
    rsp_word_d  = rsp_word_q;
    rsp_ref_d   = rsp_ref_q;
    addr_d      = addr_q;
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride_d    = stride_q;
    ref_base_d  = ref_base_q;
`endif
    if (state_q == S_CONFIG) begin
      cfg_words_d = words_in_s;
      cfg_lib_d   = hsp_library_size_i;
      word_idx_d  = W_ZERO;
      ref_idx_d   = L_ZERO;
      rsp_word_d  = W_ZERO;
      rsp_ref_d   = L_ZERO;
      addr_d      = lib_base_addr_i;
`ifdef HSID_REF_FETCH_STRIDE_EN
      stride_d    = lib_stride_i;
      ref_base_d  = lib_base_addr_i;
`endif
    end else if ((state_q == S_DONE) || (state_q == S_ERROR) || (state_q == S_CLEAR)) begin
      word_idx_d = W_ZERO;
      ref_idx_d  = L_ZERO;
      rsp_word_d = W_ZERO;
      rsp_ref_d  = L_ZERO;
    end else begin
      if (gnt_s) begin
        if (word_last_s) begin
          word_idx_d = W_ZERO;
          ref_idx_d  = ref_idx_q + L_ONE;
`ifdef HSID_REF_FETCH_STRIDE_EN
          addr_d     = ref_base_q + stride_q;
          ref_base_d = ref_base_q + stride_q;
`else
          addr_d     = addr_q + WORD_BYTES;
`endif
        end else begin
          word_idx_d = word_idx_q + W_ONE;
          addr_d     = addr_q + WORD_BYTES;
        end
      end else begin
        addr_d = addr_q;
      end
      if (push_s) begin
        if (rsp_last_s) begin
          rsp_word_d = W_ZERO;
          rsp_ref_d  = rsp_ref_q + L_ONE;
        end else begin
          rsp_word_d = rsp_word_q + W_ONE;
        end
      end else begin
        rsp_word_d = rsp_word_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clr_pend_q  <= 1'b0;
      cfg_words_q <= W_ZERO;
      cfg_lib_q   <= L_ZERO;
      word_idx_q  <= W_ZERO;
      ref_idx_q   <= L_ZERO;
      rsp_word_q  <= W_ZERO;
      rsp_ref_q   <= L_ZERO;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      credits_q   <= CRED_FULL;
      outst_q     <= OUT_ZERO;
`ifdef HSID_REF_FETCH_STRIDE_EN
      stride_q    <= {ADDR_WIDTH{1'b0}};
      ref_base_q  <= {ADDR_WIDTH{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      clr_pend_q  <= clr_pend_d;
      cfg_words_q <= cfg_words_d;
      cfg_lib_q   <= cfg_lib_d;
      word_idx_q  <= word_idx_d;
      ref_idx_q   <= ref_idx_d;
      rsp_word_q  <= rsp_word_d;
      rsp_ref_q   <= rsp_ref_d;
      addr_q      <= addr_d;
      credits_q   <= credits_d;
      outst_q     <= outst_d;
`ifdef HSID_REF_FETCH_STRIDE_EN
      stride_q    <= stride_d;
      ref_base_q  <= ref_base_d;
`endif
    end
  end

endmodule

// File: tb/tb_hsid_ref_fetch_ctrl.sv
// Directed bench for hsid_ref_fetch_ctrl: config table plus hand-written stall/clear/credit sequences.
module tb_hsid_ref_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, clear, start;
  logic [8:0]  bands;
  logic [7:0]  lib;
  logic [31:0] base;
`ifdef HSID_REF_FETCH_STRIDE_EN
  logic [31:0] stride;
`endif
  logic idle, busy, done, error, cancelled;

  always #5 clk = ~clk;

  hsid_ref_fetch_ctrl_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  hsid_ref_fetch_ctrl dut (
    .clk(clk), .rst(rst), .clear_i(clear), .start_i(start),
    .hsp_bands_i(bands), .hsp_library_size_i(lib), .lib_base_addr_i(base),
`ifdef HSID_REF_FETCH_STRIDE_EN
    .lib_stride_i(stride),
`endif
    .bus_if(bus.master),
    .idle_o(idle), .busy_o(busy), .done_o(done), .error_o(error), .cancelled_o(cancelled)
  );

  int total = 0;
  int bad   = 0;

  // memory / FIFO environment state
  bit gnt_en = 1'b1, pop_en = 1'b1, pop_once = 1'b0, ovf = 1'b0;
  int rv_delay = 1, cyc = 0;
  int grants, pushes, rvs, out_cnt, max_out, fifo_cnt, done_cnt, err_cnt, canc_cnt, req_seen, rv_seq;
  int due_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];
  bit          last_log[$];

  typedef struct {
    logic [8:0]  bands;
    logic [7:0]  lib;
    logic [31:0] base;
    logic [31:0] stride;
    bit          exp_err;
    int          exp_n;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reset_log();
    grants = 0; pushes = 0; rvs = 0; out_cnt = 0; max_out = 0; done_cnt = 0;
    err_cnt = 0; canc_cnt = 0; req_seen = 0; rv_seq = 0;
    due_q.delete(); addr_log.delete(); data_log.delete(); last_log.delete();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // which: 0 = done, 1 = cancelled
  task automatic wait_high(input int which, input int limit, input string name);
    int n;
    n = 0;
    while (((which == 0) ? done : cancelled) !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk(name, 32'(((which == 0) ? done : cancelled)), 32'd1);
  endtask

  // Memory slave and FIFO model: drives at negedge, samples 1 time unit later.
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.fifo_ref_pop = 1'b0;
    fifo_cnt = 0;
    reset_log();
    forever begin
      @(negedge clk);
      cyc++;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hD000_0000 | 32'(rv_seq);
        rv_seq++;
      end else begin
        bus.mem_rvalid = 1'b0;
      end
      bus.mem_gnt = gnt_en;
      if ((pop_en || pop_once) && fifo_cnt > 0) begin
        bus.fifo_ref_pop = 1'b1;
        fifo_cnt--;
        pop_once = 1'b0;
      end else begin
        bus.fifo_ref_pop = 1'b0;
      end
      #1;
      if (bus.mem_req) req_seen++;
      if (bus.mem_req && bus.mem_gnt) begin
        grants++;
        addr_log.push_back(bus.mem_addr);
        due_q.push_back(cyc + rv_delay);
        out_cnt++;
      end
      if (bus.mem_rvalid) begin
        out_cnt--;
        rvs++;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (bus.fifo_ref_push) begin
        pushes++;
        fifo_cnt++;
        data_log.push_back(bus.fifo_ref_data);
        last_log.push_back(bus.fifo_ref_last);
        if (fifo_cnt > 8) ovf = 1'b1;
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (cancelled) canc_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int words, n;
    rst = 1'b1; clear = 1'b0; start = 1'b0; bands = 9'd0; lib = 8'd0; base = 32'h0;
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride = 32'h0;
`endif
    //            bands  lib    base           stride     err   n
    vecs[0] = '{9'd5,  8'd3, 32'h0000_1000, 32'd12, 1'b0, 9};
    vecs[1] = '{9'd0,  8'd3, 32'h0000_1000, 32'd16, 1'b1, 0};
    vecs[2] = '{9'd5,  8'd0, 32'h0000_1000, 32'd16, 1'b1, 0};
    vecs[3] = '{9'd5,  8'd3, 32'h0000_1002, 32'd16, 1'b1, 0};
    vecs[4] = '{9'd1,  8'd1, 32'h0000_2000, 32'd4,  1'b0, 1};
    vecs[5] = '{9'd2,  8'd4, 32'h0000_2100, 32'd4,  1'b0, 4};
    vecs[6] = '{9'd6,  8'd2, 32'h0000_3000, 32'd12, 1'b0, 6};

    tick(3);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cancelled", 32'(cancelled), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_idle", 32'(idle), 32'd1);

    for (int i = 0; i < 7; i++) begin
      reset_log();
      gnt_en = 1'b1; pop_en = 1'b1; rv_delay = 1;
      bands = vecs[i].bands; lib = vecs[i].lib; base = vecs[i].base;
`ifdef HSID_REF_FETCH_STRIDE_EN
      stride = vecs[i].stride;
`endif
      words = (int'(vecs[i].bands) + 1) / 2;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk($sformatf("v%0d_cfg_idle", i), 32'(idle), 32'd0);
      chk($sformatf("v%0d_cfg_busy", i), 32'(busy), 32'd0);
      tick(1);
      chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(!vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        tick(1);
        chk($sformatf("v%0d_error_fall", i), 32'(error), 32'd0);
        chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'd1);
        chk($sformatf("v%0d_no_req", i), 32'(req_seen), 32'd0);
        chk($sformatf("v%0d_idle", i), 32'(idle), 32'd1);
      end else begin
        wait_high(0, 200, $sformatf("v%0d_done_seen", i));
        tick(1);
        chk($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
        chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_idle", i), 32'(idle), 32'd1);
        chk($sformatf("v%0d_grants", i), 32'(grants), 32'(vecs[i].exp_n));
        chk($sformatf("v%0d_pushes", i), 32'(pushes), 32'(vecs[i].exp_n));
        for (int k = 0; k < vecs[i].exp_n && k < addr_log.size() && k < last_log.size(); k++) begin
          chk($sformatf("v%0d_addr%0d", i, k), addr_log[k], vecs[i].base + 32'(4 * k));
          chk($sformatf("v%0d_last%0d", i, k), 32'(last_log[k]), 32'((k % words) == (words - 1)));
          chk($sformatf("v%0d_data%0d", i, k), data_log[k], 32'hD000_0000 | 32'(k));
        end
      end
    end

    // Grant stalled 4 cycles: request and address must hold; rvalid 3 cycles late.
    reset_log();
    gnt_en = 1'b0; rv_delay = 3; pop_en = 1'b1;
    bands = 9'd4; lib = 8'd2; base = 32'h0000_4000;
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride = 32'd8;
`endif
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_req%0d", k), 32'(bus.mem_req), 32'd1);
      chk($sformatf("stall_addr%0d", k), bus.mem_addr, 32'h0000_4000);
      tick(1);
    end
    gnt_en = 1'b1;
    wait_high(0, 200, "stall_done_seen");
    chk("stall_grants", 32'(grants), 32'd4);
    chk("stall_max_outstanding", 32'(max_out), 32'd2);
    for (int k = 0; k < 4 && k < addr_log.size(); k++)
      chk($sformatf("stall_addr_seq%0d", k), addr_log[k], 32'h0000_4000 + 32'(4 * k));
    tick(1);

    // Clear with two reads in flight.
    reset_log();
    gnt_en = 1'b1; rv_delay = 4; pop_en = 1'b1;
    bands = 9'd16; lib = 8'd2; base = 32'h0000_5000;
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride = 32'd32;
`endif
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (out_cnt != 2 && n < 30) begin
      tick(1);
      n++;
    end
    chk("clr_outstanding", 32'(out_cnt), 32'd2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    wait_high(1, 40, "clr_cancel_seen");
    chk("clr_grants", 32'(grants), 32'd2);
    chk("clr_rvalids", 32'(rvs), 32'd2);
    chk("clr_pushes", 32'(pushes), 32'd0);
    tick(1);
    chk("clr_cancel_fall", 32'(cancelled), 32'd0);
    chk("clr_cancel_cnt", 32'(canc_cnt), 32'd1);
    chk("clr_idle", 32'(idle), 32'd1);

    // No pops: credits must cap issue at FIFO depth; one pop frees one request.
    reset_log();
    gnt_en = 1'b1; rv_delay = 1; pop_en = 1'b0;
    bands = 9'd32; lib = 8'd2; base = 32'h0000_6000;
`ifdef HSID_REF_FETCH_STRIDE_EN
    stride = 32'd64;
`endif
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    chk("cred_grants", 32'(grants), 32'd8);
    chk("cred_req_low", 32'(bus.mem_req), 32'd0);
    chk("cred_pushes", 32'(pushes), 32'd8);
    pop_once = 1'b1;
    tick(10);
    chk("cred_one_more", 32'(grants), 32'd9);
    chk("cred_req_low2", 32'(bus.mem_req), 32'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    wait_high(1, 40, "cred_cancel_seen");
    tick(1);
    fifo_cnt = 0;
    pop_en = 1'b1;

`ifdef HSID_REF_FETCH_STRIDE_EN
    reset_log();
    bands = 9'd4; lib = 8'd2; base = 32'h0000_0100; stride = 32'h40;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_high(0, 100, "stride_done_seen");
    chk("stride_grants", 32'(grants), 32'd4);
    for (int k = 0; k < 4 && k < addr_log.size(); k++)
      chk($sformatf("stride_addr%0d", k), addr_log[k],
          32'h100 + 32'((k / 2) * 32'h40) + 32'(4 * (k % 2)));
    tick(1);
    stride = 32'h4;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("stride_short_err", 32'(error), 32'd1);
    tick(1);
`endif

    chk("fifo_no_overflow", 32'(ovf), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
